// File: rtl/led_flow_if.sv
// ---------------------------------------------------------------------------
// led_flow_if
//   Groups the run-time controls and LED outputs of the LED chaser.
//   The controller side (board logic or testbench) uses the master modport.
//   The chaser itself uses the slave modport.
//
// Parameters
//   N_LED      number of LEDs driven by the chaser
//
// Signals
//   en         1 = run, 0 = hold counter and pattern
//   mode       0 rot-left, 1 rot-right, 2 ping-pong, 3 fill/drain
//   speed      step period = TICK_DIV >> speed clocks
//   duty       brightness, only used when the chaser is built with LED_DIM_EN
//   led        LED drive, 1 = lit, bit 0 = first LED
//   step_pulse one-cycle strobe in the cycle led takes a new pattern value
// ---------------------------------------------------------------------------
interface led_flow_if #(
  parameter int N_LED = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [1:0]       speed;
  logic [3:0]       duty;
  logic [N_LED-1:0] led;
  logic             step_pulse;

  modport master (
    output en,
    output mode,
    output speed,
    output duty,
    input  led,
    input  step_pulse
  );

  modport slave (
    input  en,
    input  mode,
    input  speed,
    input  duty,
    output led,
    output step_pulse
  );
endinterface

// File: rtl/led_flow_gen.sv
// ---------------------------------------------------------------------------
// led_flow_gen
//   Parametrised LED chaser. A step counter divides the board clock; every
//   time it expires ("tick") the LED pattern either advances one step in the
//   current mode or, if the requested mode differs from the active one,
//   reloads the new mode's starting pattern.
//
// Parameters
//   N_LED      number of LEDs (>= 2)
//   TICK_DIV   clocks per step at speed 0 (>= 8)
//
// Ports
//   clk        system clock, all logic on the rising edge
//   reset      synchronous, active-high reset
//   bus        led_flow_if slave modport: en, mode, speed, duty in;
//              led, step_pulse out (both registered)
//
// Build option
//   LED_DIM_EN  when defined, a free-running 4-bit PWM counter gates the
//               LEDs so they are lit while pwm_cnt < duty. When undefined,
//               duty is ignored and led shows the pattern directly.
// ---------------------------------------------------------------------------
module led_flow_gen #(
  parameter int N_LED    = 8,
  parameter int TICK_DIV = 25_000_000
) (
  input logic       clk,
  input logic       reset,
  led_flow_if.slave bus
);

  localparam int CNT_W = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    MODE_ROT_L = 2'd0,
    MODE_ROT_R = 2'd1,
    MODE_PING  = 2'd2,
    MODE_FILL  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [N_LED-1:0] PAT_LSB  = {{(N_LED-1){1'b0}}, 1'b1};
  localparam logic [N_LED-1:0] PAT_MSB  = {1'b1, {(N_LED-1){1'b0}}};
  localparam logic [N_LED-1:0] PAT_ZERO = {N_LED{1'b0}};
  localparam logic [N_LED-1:0] PAT_ONES = {N_LED{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Starting pattern loaded when a tick switches to a new mode.
  function automatic logic [N_LED-1:0] init_pat(input mode_e m);
    logic [N_LED-1:0] p;
    case (m)
      MODE_ROT_L: p = PAT_LSB;
      MODE_ROT_R: p = PAT_MSB;
      MODE_PING:  p = PAT_LSB;
      MODE_FILL:  p = PAT_ZERO;
      default:    p = PAT_LSB;
    endcase
    return p;
  endfunction

  // Rotate left: MSB wraps into bit 0.
  function automatic logic [N_LED-1:0] rot_left(input logic [N_LED-1:0] p);
    return {p[N_LED-2:0], p[N_LED-1]};
  endfunction

  // Rotate right: bit 0 wraps into the MSB.
  function automatic logic [N_LED-1:0] rot_right(input logic [N_LED-1:0] p);
    return {p[0], p[N_LED-1:1]};
  endfunction

  // Fill/drain step. Filling patterns (0..01, 0..011, ...) always have bit 0
  // set, draining ones (1..10, 1..100, ...) always have it clear, so the
  // pattern itself tells which phase we are in; no extra state is needed.
  function automatic logic [N_LED-1:0] fill_step(input logic [N_LED-1:0] p);
    logic [N_LED-1:0] n;
    if (p == PAT_ONES) begin
      n = {p[N_LED-2:0], 1'b0};
    end else if ((p == PAT_ZERO) || p[0]) begin
      n = {p[N_LED-2:0], 1'b1};
    end else begin
      n = {p[N_LED-2:0], 1'b0};
    end
    return n;
  endfunction

  // State registers
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [N_LED-1:0] pat_q,        pat_d;
  dir_e             dir_q,        dir_d;
  mode_e            mode_q,       mode_d;
  logic             step_pulse_q, step_pulse_d;
  logic [N_LED-1:0] led_q,        led_d;

  // Tick decode
  logic [31:0]      limit_s;
  logic [31:0]      last_s;
  logic [31:0]      cnt_ext_s;
  logic             tick_s;
  mode_e            mode_in_s;
  logic             pwm_on_s;

`ifdef LED_DIM_EN
  logic [3:0]       pwm_cnt_q;

  // Free-running brightness counter; runs regardless of en.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q <= 4'd0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 4'd1;
    end
  end

  assign pwm_on_s = (pwm_cnt_q < bus.duty);
`else
  assign pwm_on_s = 1'b1;
`endif

  // Step period from the live speed input. Using >= rather than == means a
  // speed increase that lands below the current count ticks immediately.
  always_comb begin
    limit_s   = 32'(TICK_DIV) >> bus.speed;
    last_s    = limit_s - 32'd1;
    cnt_ext_s = 32'(cnt_q);
    mode_in_s = mode_e'(bus.mode);
    tick_s    = bus.en && (cnt_ext_s >= last_s);
  end

  // Next-state logic for the counter, pattern, direction and active mode.
  always_comb begin
    cnt_d        = cnt_q;
    pat_d        = pat_q;
    dir_d        = dir_q;
    mode_d       = mode_q;
    step_pulse_d = 1'b0;

    if (!bus.en) begin
      // hold everything; defaults already do that
      step_pulse_d = 1'b0;
    end else if (!tick_s) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d        = CNT_ZERO;
      step_pulse_d = 1'b1;
      if (mode_in_s != mode_q) begin
        // Mode switch: reload only, the new mode steps from the next tick.
        mode_d = mode_in_s;
        pat_d  = init_pat(mode_in_s);
        dir_d  = DIR_UP;
      end else begin
        case (mode_q)
          MODE_ROT_L: pat_d = rot_left(pat_q);
          MODE_ROT_R: pat_d = rot_right(pat_q);
          MODE_PING: begin
            // Reverse at the ends without repeating the end LED.
            if (dir_q == DIR_UP) begin
              if (pat_q[N_LED-1]) begin
                dir_d = DIR_DOWN;
                pat_d = pat_q >> 1;
              end else begin
                dir_d = DIR_UP;
                pat_d = pat_q << 1;
              end
            end else begin
              if (pat_q[0]) begin
                dir_d = DIR_UP;
                pat_d = pat_q << 1;
              end else begin
                dir_d = DIR_DOWN;
                pat_d = pat_q >> 1;
              end
            end
          end
          MODE_FILL:  pat_d = fill_step(pat_q);
          default:    pat_d = PAT_LSB;
        endcase
      end
    end

    // led is registered from the next pattern so it changes in the same
    // cycle as step_pulse.
    if (pwm_on_s) begin
      led_d = pat_d;
    end else begin
      led_d = PAT_ZERO;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= CNT_ZERO;
      pat_q        <= PAT_LSB;
      dir_q        <= DIR_UP;
      mode_q       <= MODE_ROT_L;
      step_pulse_q <= 1'b0;
      led_q        <= PAT_LSB;
    end else begin
      cnt_q        <= cnt_d;
      pat_q        <= pat_d;
      dir_q        <= dir_d;
      mode_q       <= mode_d;
      step_pulse_q <= step_pulse_d;
      led_q        <= led_d;
    end
  end

  assign bus.led        = led_q;
  assign bus.step_pulse = step_pulse_q;

endmodule
